digest_stream_serializer: RTL

//  Turns squeezed sponge rate blocks into a big-endian digest stream of OUT_W-bit words, each byte-reversed.

---
 rtl/digest_stream_serializer.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/digest_stream_serializer.sv
// digest_stream_serializer
//   Takes squeezed sponge rate blocks and emits them as a stream of OUT_W-bit
//   digest words.
//   - Each word is byte-reversed, so byte 0 of the word lands in the MSB.
//   - A job asks for cfg_words words. When a block runs out before the job
//     ends, the block asks for another squeeze (XOF output).
//   - Words beyond the end of the job in the final block are dropped.
//   Optional feature macro: DIGEST_SER_SWAP_SEL_EN adds a cfg_le input,
//   sampled with start. With cfg_le=1 the words go out without byte reversal.
module digest_stream_serializer #(
  parameter int IN_W  = 1088,
  parameter int OUT_W = 64,
  parameter int LEN_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  cfg_words,
`ifdef DIGEST_SER_SWAP_SEL_EN
  input  logic              cfg_le,
`endif
  input  logic [IN_W-1:0]   in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  // Words per rate block, bytes per word, and the word-index width.
  localparam int WPB   = IN_W / OUT_W;
  localparam int NBYTE = OUT_W / 8;
  localparam int IDX_W = (WPB > 1) ? $clog2(WPB) : 1;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WPB - 1);
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_BLK = 2'd1,
    S_EMIT     = 2'd2
  } state_t;

  state_t            state_q,     state_d;
  logic [IN_W-1:0]   buf_q,       buf_d;
  logic [IDX_W-1:0]  idx_q,       idx_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic              done_q,      done_d;

  // Byte reversal can only be turned off when the select feature is built in.
  logic              swap_en;
`ifdef DIGEST_SER_SWAP_SEL_EN
  logic              le_q,        le_d;
  assign swap_en = ~le_q;
`else
  assign swap_en = 1'b1;
`endif

  // Word picked from the buffer, and the same word with its bytes reversed.
  logic [OUT_W-1:0]  cur_word;
  logic [OUT_W-1:0]  swapped_word;

  // Next-state logic: job start, block capture, and word countdown.
  always_comb begin
    // NOTE: every variable gets a default before the case. Any path that
    // leaves one unassigned would turn it into a latch.
    state_d     = state_q;
    buf_d       = buf_q;
    idx_d       = idx_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
`ifdef DIGEST_SER_SWAP_SEL_EN
    le_d        = le_q;
`endif

    case (state_q)
      S_IDLE: begin
        // A zero-length request is dropped here, so it never raises busy
        // or done.
        if (start && (cfg_words != '0)) begin
          remaining_d = cfg_words;
`ifdef DIGEST_SER_SWAP_SEL_EN
          le_d        = cfg_le;
`endif
          state_d     = S_WAIT_BLK;
        end
      end

      S_WAIT_BLK: begin
        // in_ready is high only in this state, so in_valid by itself is the
        // handshake.
        if (in_valid) begin
          buf_d   = in_data;
          idx_d   = '0;
          state_d = S_EMIT;
        end
      end

      S_EMIT: begin
        if (out_ready) begin
          remaining_d = remaining_q - LEN_ONE;
          if (remaining_q == LEN_ONE) begin
            // Final word of the job. The rest of the block is dropped.
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else if (idx_q == IDX_LAST) begin
            // Block used up while the job still needs words: ask for
            // another squeeze.
            state_d = S_WAIT_BLK;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register. rst is synchronous and overrides every other input.
  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments only. Every flop then sees
    // the values from before the clock edge, whatever order the statements
    // are written in.
    if (rst) begin
      state_q     <= S_IDLE;
      // NOTE: the wide buffer is cleared on reset on purpose. out_data reads
      // it directly, and it must come out of reset at a known value.
      buf_q       <= '0;
      idx_q       <= '0;
      remaining_q <= '0;
      done_q      <= 1'b0;
`ifdef DIGEST_SER_SWAP_SEL_EN
      le_q        <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      idx_q       <= idx_d;
      remaining_q <= remaining_d;
      done_q      <= done_d;
`ifdef DIGEST_SER_SWAP_SEL_EN
      le_q        <= le_d;
`endif
    end
  end

  // Word select and byte reversal. Both come from registered state only, so
  // out_data cannot change while the sink holds off.
  always_comb begin
    cur_word     = '0;
    swapped_word = '0;
    for (int k = 0; k < WPB; k++) begin
      if (idx_q == IDX_W'(k)) begin
        cur_word = buf_q[k*OUT_W +: OUT_W];
      end
    end
    for (int b = 0; b < NBYTE; b++) begin
      swapped_word[OUT_W-1-8*b -: 8] = cur_word[8*b +: 8];
    end
  end

  // Handshake and status outputs decoded from the current state.
  always_comb begin
    in_ready  = (state_q == S_WAIT_BLK);
    out_valid = (state_q == S_EMIT);
    out_last  = (state_q == S_EMIT) && (remaining_q == LEN_ONE);
    busy      = (state_q != S_IDLE);
    done      = done_q;
    out_data  = '0;
    if (state_q == S_EMIT) begin
      out_data = swap_en ? swapped_word : cur_word;
    end
  end

endmodule
